// File: rtl/sel_pipe_mux_pkg.sv
// Shared types and default sizing for the selecting pipeline mux.
package sel_pipe_mux_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 4;

  // Occupancy of the output storage (main entry, plus skid entry when built in).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/sel_pipe_mux_if.sv
// Handshake bundle for sel_pipe_mux: upstream offer (data/sel/valid/ready),
// downstream result (data/valid/ready) and the illegal-select pulse.
// The master side is the environment, the slave side is the mux block.
interface sel_pipe_mux_if
  import sel_pipe_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) ();

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  modport master (
    output in_data, sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_data, sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );

endinterface

// File: rtl/sel_pipe_mux_mux_n.sv
// mux_n: combinational N-way selector. A select value with no matching
// input yields all-zero data and raises sel_bad.
module mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    sel_bad
);

  // Scan the legal inputs; only an exact select match routes data through.
  always_comb begin
    out_data = '0;
    sel_bad  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        out_data = in_data[i*WIDTH +: WIDTH];
        sel_bad  = 1'b0;
      end else begin
        out_data = out_data;
      end
    end
  end

endmodule

// File: rtl/sel_pipe_mux.sv
// sel_pipe_mux: selects one of NUM_IN inputs on an accepted transfer and
// presents it registered on a valid/ready output.
// Build option SEL_PIPE_MUX_SKID_EN adds a skid entry so that in_ready is a
// pure register output; without it the block is a single-entry pipe whose
// in_ready is !out_valid || out_ready.
module sel_pipe_mux
  import sel_pipe_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)  // derived, leave at default
) (
  input logic           clk,
  input logic           rst,
  sel_pipe_mux_if.slave bus
);

  logic [WIDTH-1:0] mux_data_s;
  logic             mux_bad_s;

  occ_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;
  logic             in_ready_s;
  logic             in_xfer_s;
  logic             out_xfer_s;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .in_data  (bus.in_data),
    .sel      (bus.sel),
    .out_data (mux_data_s),
    .sel_bad  (mux_bad_s)
  );

  assign in_xfer_s  = bus.in_valid && in_ready_s;
  assign out_xfer_s = out_valid_q && bus.out_ready;

`ifdef SEL_PIPE_MUX_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;

  assign in_ready_s = in_ready_q;

  // Occupancy FSM with skid: a second entry absorbs one beat of backpressure.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer_s) begin
          state_d = ONE;
          main_d  = mux_data_s;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (in_xfer_s && out_xfer_s) begin
          main_d = mux_data_s;
        end else if (in_xfer_s) begin
          state_d = TWO;
          skid_d  = mux_data_s;
        end else if (out_xfer_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      TWO: begin
        // in_ready is low here, so only the output side can move.
        if (out_xfer_s) begin
          state_d = ONE;
          main_d  = skid_q;
        end else begin
          state_d = TWO;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    in_ready_d = (state_d != TWO);
  end

  // Skid storage and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  // Single entry: accept whenever the entry is free or leaving this cycle.
  assign in_ready_s = !out_valid_q || bus.out_ready;

  // Occupancy FSM without skid: only EMPTY and ONE are reachable.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer_s) begin
          state_d = ONE;
          main_d  = mux_data_s;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (in_xfer_s) begin
          main_d = mux_data_s;
        end else if (out_xfer_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end
`endif

  // Output flags derived from the next occupancy and the current accept.
  always_comb begin
    out_valid_d = (state_d != EMPTY);
    sel_err_d   = in_xfer_s && mux_bad_s;
  end

  // State, main entry and output flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = main_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: doc/sel_pipe_mux.md
SEL_PIPE_MUX -- requirements
Module: sel_pipe_mux

Interface
REQ-001 Parameter WIDTH, default 32, data width per input in bits.
REQ-002 Parameter NUM_IN, default 4, number of data inputs; legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(NUM_IN), select width; it is derived and SHALL NOT be overridden.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_data  input  NUM_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  selects the input captured on an accepted transfer.
REQ-008 in_valid  input  1  upstream offers in_data/sel.
REQ-009 in_ready  output  1  block accepts this cycle.
REQ-010 out_data  output  WIDTH  selected, registered data.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 sel_err  output  1  one-cycle pulse: an accepted transfer carried sel >= NUM_IN.

Function
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-015 On an input transfer the block SHALL capture in_data[sel*WIDTH +: WIDTH]; if sel >= NUM_IN it SHALL capture all-zero data.
REQ-016 Storage is two entries, main and skid; occupancy FSM states EMPTY, ONE, TWO.
REQ-017 Transitions: EMPTY -> ONE on input only; ONE -> TWO on input without output; ONE -> EMPTY on output without input; ONE stays ONE on both; TWO -> ONE on output (no input possible); all other cases hold the current state.
REQ-018 out_valid = (state != EMPTY); out_data always comes from the main entry; on leaving TWO, skid moves to main in the same edge.
REQ-019 Latency: data accepted at edge N appears on out_data with out_valid high after edge N, at the earliest.
REQ-020 Ordering is strict FIFO; no transfer is dropped, duplicated or reordered.
REQ-021 in_ready SHALL be a register output (state != TWO next cycle), with no combinational path from out_ready.
REQ-022 While out_valid && !out_ready, out_data SHALL remain stable.
REQ-023 sel_err SHALL be high for exactly the cycle after an accepted transfer with an illegal sel; it is low otherwise.

Reset
REQ-024 When rst is high at a clock edge: state = EMPTY, out_valid = 0, out_data = 0, skid = 0, sel_err = 0, in_ready = 1 in the following cycle.
REQ-025 Reset mid-operation SHALL discard both entries; no output transfer SHALL occur after that edge until new data is accepted.

Configuration
REQ-026 Macro SEL_PIPE_MUX_SKID_EN: when defined, the behaviour is as in REQ-016..REQ-021.
REQ-027 When it is not defined, the skid entry and TWO state are removed and in_ready = !out_valid || out_ready (combinational); throughput and ordering are unchanged, and REQ-021 is waived.

Structure
REQ-028 Package sel_pipe_mux_pkg SHALL hold the occupancy state enum (EMPTY/ONE/TWO) and the default WIDTH/NUM_IN constants.
REQ-029 A combinational sub-module mux_n (WIDTH, NUM_IN) SHALL perform the selection, including the zero output for an illegal select; sel_pipe_mux instantiates it once.

Verification
REQ-030 Reset, then send sel=2 with input2=0x0000_00AA and out_ready=1 -> out_data=0x0000_00AA, out_valid=1 one cycle later, sel_err=0.
REQ-031 Hold out_ready=0 and send two transfers (0x11, 0x22) -> in_ready=0 after the second; out_data stays 0x11; raising out_ready delivers 0x11 then 0x22 on consecutive cycles.
REQ-032 Run a continuous stream of 100 transfers with out_ready=1 -> one output per cycle, in order, in_ready never drops.
REQ-033 With NUM_IN=3, send sel=3 -> out_data=0, sel_err=1 for exactly one cycle.
REQ-034 Raise rst while state=TWO -> out_valid=0, out_data=0 next cycle; 0x11/0x22 never appear at the output.
REQ-035 Build without SEL_PIPE_MUX_SKID_EN and apply random out_ready backpressure -> in_ready tracks !out_valid||out_ready combinationally, and the sequence matches the reference model.
